bf_sram_arbiter: RTL and testbench
==================================

BF_SRAM_ARBITER -- requirements
Module: bf_sram_arbiter

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WIDTH, default 18, SRAM word address width.
REQ-002 SHALL have parameter SRAM_DATA_WIDTH, default 72, SRAM word width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive A grants allowed while B waits.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port a_req  in  1  lookup/insert client request, held until a_gnt.
REQ-007 SHALL have port a_wr  in  1  1=write, 0=read; stable while a_req.
REQ-008 SHALL have ports a_addr  in  SRAM_ADDR_WIDTH and a_wdata  in  SRAM_DATA_WIDTH, stable while a_req.
REQ-009 SHALL have port a_gnt  out  1  one-cycle accept pulse.
REQ-010 SHALL have ports b_req, b_wr, b_addr, b_wdata, b_gnt  identical to A, for the aging/shift sweeper.
REQ-011 SHALL have port cli_rdata  out  SRAM_DATA_WIDTH  read return data, shared.
REQ-012 SHALL have ports a_rvld, b_rvld  out  1  cli_rdata valid for that client.
REQ-013 SHALL have ports rd_0_req  out  1; rd_0_addr  out  SRAM_ADDR_WIDTH; rd_0_ack  in  1; rd_0_vld  in  1; rd_0_data  in  SRAM_DATA_WIDTH.
REQ-014 SHALL have ports wr_0_req  out  1; wr_0_addr  out  SRAM_ADDR_WIDTH; wr_0_data  out  SRAM_DATA_WIDTH; wr_0_ack  in  1.

Function
REQ-015 SHALL use FSM IDLE, RD_WAIT, WR_WAIT.
REQ-016 Eligible client SHALL be req=1 and (wr=1 or tag FIFO not full).
REQ-017 In IDLE with an eligible client, SHALL pulse that client's gnt combinationally in the same cycle, latch addr/wdata, and enter RD_WAIT or WR_WAIT.
REQ-018 SHALL assert rd_0_req/wr_0_req from the cycle after gnt, holding addr/data stable until ack is sampled, then deassert and return to IDLE on the next edge; at most one SRAM request outstanding on the req/ack side at any time.
REQ-019 SHALL grant A when both are eligible, unless the starve counter equals STARVE_LIMIT, in which case B is granted.
REQ-020 Starve counter SHALL increment on each A grant while b_req=1, saturate at STARVE_LIMIT, and clear on B grant or when b_req=0.
REQ-021 SHALL push the client id into a 4-entry tag FIFO on each read grant and pop on rd_0_vld.
REQ-022 On rd_0_vld, SHALL register rd_0_data into cli_rdata and pulse a_rvld or b_rvld per the popped tag one cycle later; returns stay in issue order.
REQ-023 rd_0_vld with tag FIFO empty SHALL be discarded with no rvld pulse.
REQ-024 Grant and rd_0_vld in the same cycle SHALL push and pop together; occupancy unchanged.
REQ-025 With 4 reads outstanding, SHALL stall reads only; an eligible write from either client is still granted.
REQ-026 Ack arriving in the same cycle the request first rises SHALL be honoured (minimum 2 cycles per access).

Reset
REQ-027 On reset, SHALL set FSM to IDLE and zero rd_0_req, wr_0_req, addresses, wr_0_data, gnts, rvlds, cli_rdata and the starve counter, and flush the tag FIFO.
REQ-028 Reset mid-access SHALL drop the SRAM request immediately; rd_0_vld after reset SHALL be discarded under REQ-023.

Configuration
REQ-029 With BF_ARB_STARVE_EN defined, SHALL implement REQ-019/020; undefined, SHALL use strict A priority with no starve counter.

Verification
REQ-030 Bench: A read at 0x00010, ack after 2 cycles, vld 3 cycles later with 0xAB..CD -> a_gnt once, rd_0_addr=0x00010, a_rvld one cycle after vld with that data.
REQ-031 Bench: A and B both request continuously, STARVE_EN on, STARVE_LIMIT=4 -> grants A,A,A,A,B repeating; with macro off -> B never granted.
REQ-032 Bench: B issues 4 reads with no vld, then B read and A write pending -> A write granted, B read stalled until first vld.
REQ-033 Bench: A read then B read, vld returned in order -> a_rvld then b_rvld, data matching issue order.
REQ-034 Bench: reset asserted while wr_0_req=1 awaiting ack -> wr_0_req=0 next cycle; stray rd_0_vld afterwards -> no rvld.

Source files
------------

// File: rtl/bf_sram_arbiter.sv
// bf_sram_arbiter: arbitrates client A (lookup/insert) and client B (aging sweeper) onto one
//   SRAM read/write port pair; read returns are steered back in issue order by a 4-entry tag FIFO.
// Latency: gnt is combinational in IDLE; the SRAM request rises the next cycle and is held to ack;
//   read data reaches cli_rdata one cycle after rd_0_vld.
// Backpressure: one SRAM access in flight on req/ack; reads stall while 4 reads are unreturned,
//   writes are still granted.
// Ports: clk/reset; per-client req/wr/addr/wdata in and gnt out; shared cli_rdata with a_rvld/b_rvld;
//   SRAM read side rd_0_req/addr out, ack/vld/data in; SRAM write side wr_0_req/addr/data out, ack in.
// Config: define BF_ARB_STARVE_EN to let B win after STARVE_LIMIT back-to-back A grants while B waits;
//   without it A has strict priority and there is no starve counter.
module bf_sram_arbiter #(
  parameter int SRAM_ADDR_WIDTH = 18,
  parameter int SRAM_DATA_WIDTH = 72,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       a_req,
  input  logic                       a_wr,
  input  logic [SRAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] a_wdata,
  output logic                       a_gnt,
  input  logic                       b_req,
  input  logic                       b_wr,
  input  logic [SRAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [SRAM_DATA_WIDTH-1:0] b_wdata,
  output logic                       b_gnt,
  output logic [SRAM_DATA_WIDTH-1:0] cli_rdata,
  output logic                       a_rvld,
  output logic                       b_rvld,
  output logic                       rd_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0] rd_0_addr,
  input  logic                       rd_0_ack,
  input  logic                       rd_0_vld,
  input  logic [SRAM_DATA_WIDTH-1:0] rd_0_data,
  output logic                       wr_0_req,
  output logic [SRAM_ADDR_WIDTH-1:0] wr_0_addr,
  output logic [SRAM_DATA_WIDTH-1:0] wr_0_data,
  input  logic                       wr_0_ack
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_WR_WAIT = 2'd2;
  localparam logic [2:0] TAG_DEPTH  = 3'd4;

  logic [1:0]                 state_q, state_d;
  logic                       rd_req_q, rd_req_d;
  logic                       wr_req_q, wr_req_d;
  logic [SRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [SRAM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SRAM_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [SRAM_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                       a_rvld_q, a_rvld_d;
  logic                       b_rvld_q, b_rvld_d;

  // Tag FIFO: one bit per slot holding the client id of an unreturned read (1 = B).
  logic [3:0] tag_q, tag_d;
  logic [1:0] tag_rd_ptr_q, tag_rd_ptr_d;
  logic [1:0] tag_wr_ptr_q, tag_wr_ptr_d;
  logic [2:0] tag_cnt_q, tag_cnt_d;

  logic tag_full, tag_empty;
  logic a_elig, b_elig, pick_a, pick_b;
  logic can_grant, grant, grant_wr;
  logic tag_push, tag_pop;
  logic starve_hit;

  assign tag_full  = (tag_cnt_q == TAG_DEPTH);
  assign tag_empty = (tag_cnt_q == 3'd0);

  // A full tag FIFO only blocks reads; writes never produce a return.
  assign a_elig = a_req && (a_wr || !tag_full);
  assign b_elig = b_req && (b_wr || !tag_full);

`ifdef BF_ARB_STARVE_EN
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == STARVE_MAX);

  // Counts A grants taken while B is asking; saturates so B keeps its turn until served.
  always_comb begin
    starve_d = starve_q;
    if (!b_req || b_gnt) begin
      starve_d = '0;
    end else if (a_gnt && !starve_hit) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;

  assign starve_hit          = 1'b0;
  assign unused_starve_limit = (STARVE_LIMIT != 0);
`endif

  assign pick_b    = b_elig && (!a_elig || starve_hit);
  assign pick_a    = a_elig && !pick_b;
  assign can_grant = (state_q == ST_IDLE) && !reset;
  assign a_gnt     = can_grant && pick_a;
  assign b_gnt     = can_grant && pick_b;
  assign grant     = a_gnt || b_gnt;
  assign grant_wr  = pick_b ? b_wr : a_wr;
  assign tag_push  = grant && !grant_wr;
  // A return with nothing outstanding has no owner and is dropped.
  assign tag_pop   = rd_0_vld && !tag_empty;

  // Access FSM: the request register mirrors RD_WAIT/WR_WAIT, so an ack seen in
  // those states is always an ack of a raised request.
  always_comb begin
    state_d   = state_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          if (grant_wr) begin
            wr_req_d  = 1'b1;
            wr_addr_d = pick_b ? b_addr : a_addr;
            wr_data_d = pick_b ? b_wdata : a_wdata;
            state_d   = ST_WR_WAIT;
          end else begin
            rd_req_d  = 1'b1;
            rd_addr_d = pick_b ? b_addr : a_addr;
            state_d   = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (rd_0_ack) begin
          rd_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (wr_0_ack) begin
          wr_req_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        rd_req_d = 1'b0;
        wr_req_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Tag FIFO bookkeeping; a push and a pop in one cycle leave the count unchanged.
  always_comb begin
    tag_d        = tag_q;
    tag_wr_ptr_d = tag_wr_ptr_q;
    tag_rd_ptr_d = tag_rd_ptr_q;
    tag_cnt_d    = tag_cnt_q;
    if (tag_push) begin
      tag_d[tag_wr_ptr_q] = pick_b;
      tag_wr_ptr_d        = tag_wr_ptr_q + 2'd1;
    end
    if (tag_pop) begin
      tag_rd_ptr_d = tag_rd_ptr_q + 2'd1;
    end
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 3'd1;
      2'b01:   tag_cnt_d = tag_cnt_q - 3'd1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
  end

  always_comb begin
    a_rvld_d = tag_pop && !tag_q[tag_rd_ptr_q];
    b_rvld_d = tag_pop && tag_q[tag_rd_ptr_q];
    rdata_d  = tag_pop ? rd_0_data : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      rd_addr_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rdata_q      <= '0;
      a_rvld_q     <= 1'b0;
      b_rvld_q     <= 1'b0;
      tag_q        <= '0;
      tag_rd_ptr_q <= '0;
      tag_wr_ptr_q <= '0;
      tag_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rdata_q      <= rdata_d;
      a_rvld_q     <= a_rvld_d;
      b_rvld_q     <= b_rvld_d;
      tag_q        <= tag_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_cnt_q    <= tag_cnt_d;
    end
  end

  assign rd_0_req  = rd_req_q;
  assign rd_0_addr = rd_addr_q;
  assign wr_0_req  = wr_req_q;
  assign wr_0_addr = wr_addr_q;
  assign wr_0_data = wr_data_q;
  assign cli_rdata = rdata_q;
  assign a_rvld    = a_rvld_q;
  assign b_rvld    = b_rvld_q;

endmodule

// File: tb/tb_bf_sram_arbiter.sv
// tb_bf_sram_arbiter: directed stimulus for bf_sram_arbiter with a queue-based reference model
//   checked every cycle, plus literal expectations for the key scenarios.
module tb_bf_sram_arbiter;

  localparam int AW    = 18;
  localparam int DW    = 72;
  localparam int LIMIT = 4;

  logic          clk;
  logic          reset;
  logic          a_req, a_wr, b_req, b_wr;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt;
  logic [DW-1:0] cli_rdata;
  logic          a_rvld, b_rvld;
  logic          rd_0_req, rd_0_ack, rd_0_vld;
  logic [AW-1:0] rd_0_addr;
  logic [DW-1:0] rd_0_data;
  logic          wr_0_req, wr_0_ack;
  logic [AW-1:0] wr_0_addr;
  logic [DW-1:0] wr_0_data;

  // SRAM responder: either acks immediately (same cycle the request is seen) or by hand.
  logic auto_ack, man_rd_ack, man_wr_ack;
  assign rd_0_ack = auto_ack ? rd_0_req : man_rd_ack;
  assign wr_0_ack = auto_ack ? wr_0_req : man_wr_ack;

  int errors = 0;
  int checks = 0;

  bf_sram_arbiter #(
    .SRAM_ADDR_WIDTH(AW),
    .SRAM_DATA_WIDTH(DW),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .a_req    (a_req),
    .a_wr     (a_wr),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_gnt    (a_gnt),
    .b_req    (b_req),
    .b_wr     (b_wr),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_gnt    (b_gnt),
    .cli_rdata(cli_rdata),
    .a_rvld   (a_rvld),
    .b_rvld   (b_rvld),
    .rd_0_req (rd_0_req),
    .rd_0_addr(rd_0_addr),
    .rd_0_ack (rd_0_ack),
    .rd_0_vld (rd_0_vld),
    .rd_0_data(rd_0_data),
    .wr_0_req (wr_0_req),
    .wr_0_addr(wr_0_addr),
    .wr_0_data(wr_0_data),
    .wr_0_ack (wr_0_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // m_busy: 0 = no access, 1 = read awaiting ack, 2 = write awaiting ack.
  int            m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_tags[$];
  int            m_starve;
  logic          m_rv_a, m_rv_b;
  logic [DW-1:0] m_rdata;
  logic          started = 1'b0;
  logic          ea, eb, ga, gb, gw;
  int            pk;
  int            n_agnt = 0;

  always @(negedge clk) begin
    if (a_gnt === 1'b1) n_agnt++;
    if (started) begin
      chk("rd_0_req", rd_0_req, m_busy == 1);
      chk("wr_0_req", wr_0_req, m_busy == 2);
      if (m_busy == 1) chk("rd_0_addr", rd_0_addr, m_addr);
      if (m_busy == 2) begin
        chk("wr_0_addr", wr_0_addr, m_addr);
        chk("wr_0_data", wr_0_data, m_wdata);
      end
      chk("a_rvld", a_rvld, m_rv_a);
      chk("b_rvld", b_rvld, m_rv_b);
      chk("cli_rdata", cli_rdata, m_rdata);
    end
    ga = 1'b0;
    gb = 1'b0;
    if (!reset && m_busy == 0) begin
      ea = a_req && (a_wr || m_tags.size() < 4);
      eb = b_req && (b_wr || m_tags.size() < 4);
      if (ea && eb) begin
`ifdef BF_ARB_STARVE_EN
        if (m_starve >= LIMIT) gb = 1'b1;
        else                   ga = 1'b1;
`else
        ga = 1'b1;
`endif
      end else begin
        ga = ea;
        gb = eb;
      end
    end
    if (started) begin
      chk("a_gnt", a_gnt, ga);
      chk("b_gnt", b_gnt, gb);
    end
    if (reset) begin
      m_busy   = 0;
      m_addr   = '0;
      m_wdata  = '0;
      m_tags.delete();
      m_starve = 0;
      m_rv_a   = 1'b0;
      m_rv_b   = 1'b0;
      m_rdata  = '0;
      started  = 1'b1;
    end else begin
      m_rv_a = 1'b0;
      m_rv_b = 1'b0;
      if (rd_0_vld && m_tags.size() > 0) begin
        pk      = m_tags.pop_front();
        m_rv_a  = (pk == 0);
        m_rv_b  = (pk == 1);
        m_rdata = rd_0_data;
      end
      if (m_busy == 1 && rd_0_ack) m_busy = 0;
      else if (m_busy == 2 && wr_0_ack) m_busy = 0;
      if (ga || gb) begin
        gw      = ga ? a_wr : b_wr;
        m_busy  = gw ? 2 : 1;
        m_addr  = ga ? a_addr : b_addr;
        m_wdata = ga ? a_wdata : b_wdata;
        if (!gw) m_tags.push_back(gb ? 1 : 0);
      end
      if (!b_req || gb) m_starve = 0;
      else if (ga && m_starve < LIMIT) m_starve++;
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [DW-1:0] D_T1 = 72'hAB_1234_5678_9ABC_DE_CD;
  int         nb, ng, a0;
  logic [9:0] seq;

  initial begin
    reset = 1'b1;
    a_req = 1'b1; a_wr = 1'b1; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;
    rd_0_vld = 1'b0; rd_0_data = '0;
    auto_ack = 1'b0; man_rd_ack = 1'b0; man_wr_ack = 1'b0;

    // Reset: request held during reset must not be granted.
    repeat (3) step();
    samp();
    chk("rst_a_gnt", a_gnt, 1'b0);
    chk("rst_wr_req", wr_0_req, 1'b0);
    chk("rst_rd_req", rd_0_req, 1'b0);
    chk("rst_cli_rdata", cli_rdata, '0);
    step();
    reset = 1'b0; a_req = 1'b0; a_wr = 1'b0;
    step();

    // Single A read: ack on the second request cycle, vld three cycles later.
    a0 = n_agnt;
    a_req = 1'b1; a_wr = 1'b0; a_addr = 18'h00010;
    samp(); chk("t1_a_gnt", a_gnt, 1'b1);
    step(); a_req = 1'b0;
    samp(); chk("t1_rd_req", rd_0_req, 1'b1); chk("t1_rd_addr", rd_0_addr, 18'h00010);
    step(); man_rd_ack = 1'b1;
    samp(); chk("t1_rd_req_held", rd_0_req, 1'b1);
    step(); man_rd_ack = 1'b0;
    samp(); chk("t1_rd_req_drop", rd_0_req, 1'b0);
    step(); step();
    rd_0_vld = 1'b1; rd_0_data = D_T1;
    samp(); chk("t1_rvld_early", a_rvld, 1'b0);
    step(); rd_0_vld = 1'b0;
    samp(); chk("t1_a_rvld", a_rvld, 1'b1); chk("t1_rdata", cli_rdata, D_T1);
    step();
    samp(); chk("t1_a_rvld_pulse", a_rvld, 1'b0); chk("t1_one_gnt", n_agnt - a0, 1);

    // Both clients writing continuously.
    step();
    auto_ack = 1'b1;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 18'h00A00; a_wdata = 72'h11;
    b_req = 1'b1; b_wr = 1'b1; b_addr = 18'h00B00; b_wdata = 72'h22;
    ng = 0; seq = '0;
    for (int i = 0; i < 20; i++) begin
      samp();
      if (a_gnt || b_gnt) begin
        if (ng < 10) seq[ng] = b_gnt;
        ng++;
      end
      step();
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("t2_grant_count", ng, 10);
`ifdef BF_ARB_STARVE_EN
    chk("t2_grant_order", seq, 10'h210);
`else
    chk("t2_grant_order", seq, 10'h000);
`endif
    step(); step();

    // B fills the tag FIFO; A write still goes, B read waits for a return.
    b_req = 1'b1; b_wr = 1'b0; b_addr = 18'h00100;
    nb = 0;
    for (int i = 0; i < 20 && nb < 4; i++) begin
      samp();
      if (b_gnt) nb++;
      step();
    end
    chk("t3_reads_issued", nb, 4);
    step();
    a_req = 1'b1; a_wr = 1'b1; a_addr = 18'h00200; a_wdata = 72'h5A;
    samp(); chk("t3_a_wr_gnt", a_gnt, 1'b1); chk("t3_b_stalled", b_gnt, 1'b0);
    step(); a_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      samp(); chk("t3_b_still_stalled", b_gnt, 1'b0);
      step();
    end
    rd_0_vld = 1'b1; rd_0_data = 72'hD0;
    samp(); chk("t3_b_stalled_at_vld", b_gnt, 1'b0);
    step(); rd_0_data = 72'hD1;  // second return lands in the same cycle as the B grant
    samp(); chk("t3_b_gnt_after_vld", b_gnt, 1'b1); chk("t3_b_rvld", b_rvld, 1'b1);
    chk("t3_rdata0", cli_rdata, 72'hD0);
    step(); b_req = 1'b0; rd_0_vld = 1'b0;
    samp(); chk("t3_b_rvld1", b_rvld, 1'b1); chk("t3_rdata1", cli_rdata, 72'hD1);
    for (int i = 0; i < 3; i++) begin
      step(); rd_0_vld = 1'b1; rd_0_data = 72'hE0 + 72'(i);
    end
    step(); rd_0_vld = 1'b0;
    step(); step();

    // A read then B read, returned in order.
    a_req = 1'b1; a_wr = 1'b0; a_addr = 18'h00030;
    b_req = 1'b1; b_wr = 1'b0; b_addr = 18'h00040;
    samp(); chk("t4_a_first", a_gnt, 1'b1); chk("t4_b_waits", b_gnt, 1'b0);
    step(); a_req = 1'b0;
    step();
    samp(); chk("t4_b_gnt", b_gnt, 1'b1);
    step(); b_req = 1'b0;
    step(); rd_0_vld = 1'b1; rd_0_data = 72'hDA;
    step(); rd_0_data = 72'hDB;
    samp(); chk("t4_a_rvld", a_rvld, 1'b1); chk("t4_b_rvld_lo", b_rvld, 1'b0);
    chk("t4_rdata_a", cli_rdata, 72'hDA);
    step(); rd_0_vld = 1'b0;
    samp(); chk("t4_b_rvld", b_rvld, 1'b1); chk("t4_a_rvld_lo", a_rvld, 1'b0);
    chk("t4_rdata_b", cli_rdata, 72'hDB);
    step();

    // Reset during a pending write, with one read still unreturned.
    a_req = 1'b1; a_wr = 1'b0; a_addr = 18'h00066;
    samp(); chk("t5_rd_gnt", a_gnt, 1'b1);
    step(); a_req = 1'b0;
    step();
    auto_ack = 1'b0;
    a_req = 1'b1; a_wr = 1'b1; a_addr = 18'h00055; a_wdata = 72'h77;
    samp(); chk("t5_wr_gnt", a_gnt, 1'b1);
    step(); a_req = 1'b0;
    samp(); chk("t5_wr_req", wr_0_req, 1'b1);
    step(); reset = 1'b1;
    samp(); chk("t5_wr_req_in_rst", wr_0_req, 1'b1);
    step(); reset = 1'b0;
    samp(); chk("t5_wr_req_dropped", wr_0_req, 1'b0); chk("t5_wr_addr_rst", wr_0_addr, '0);
    step(); rd_0_vld = 1'b1; rd_0_data = 72'hFF;
    step(); rd_0_vld = 1'b0;
    samp(); chk("t5_no_a_rvld", a_rvld, 1'b0); chk("t5_no_b_rvld", b_rvld, 1'b0);
    chk("t5_rdata_kept", cli_rdata, '0);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule
